// File: rtl/dmarb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Build option: DMARB_RR_EN selects round-robin contention handling
// (default build uses fixed priority, port 0 first).
package dmarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    localparam int unsigned LOCK_MAX_DFLT = 16;
    localparam int unsigned LOCK_CNT_W    = $clog2(LOCK_MAX_DFLT + 1);

    // Width of a counter that must reach lock_max inclusive.
    function automatic int unsigned lock_cnt_w(input int unsigned lock_max);
        return $clog2(lock_max + 1);
    endfunction

endpackage

// File: rtl/dmarb_pick.sv
// Combinational two-way picker: a single request wins outright, and on
// contention the port that did not win last time is chosen.
module dmarb_pick
    import dmarb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic win_vld,
    output logic win_id
);

    // Choose the winning port for this cycle.
    always_comb begin
        win_vld = req0 | req1;
        win_id  = P0;
        if (req0 && req1) begin
            win_id = ~last_winner;
        end else if (req1) begin
            win_id = P1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port 256-word data memory.
// Port 0 = CPU MEM stage, port 1 = loader/debug DMA. Supports locked
// sequences bounded by a watchdog of LOCK_MAX consecutive owned cycles.
// Build option: DMARB_RR_EN enables round-robin on contention; without it
// port 0 has fixed priority.
module data_mem_arbiter
    import dmarb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CW      = lock_cnt_w(LOCK_MAX);
    localparam logic [CW-1:0]   CNT_MAX = CW'(LOCK_MAX);

    state_t          state;
    logic [CW-1:0]   lock_cnt;
    logic            rvalid0_q;
    logic            rvalid1_q;
    logic            pick_last;
    logic            win_vld;
    logic            win_id;
    logic            grant0;
    logic            grant1;
    logic            wd_fire;

`ifdef DMARB_RR_EN
    logic last_winner;
    assign pick_last = last_winner;
`else
    // Fixed priority is the picker with a constant "port 1 won last";
    // a watchdog release from OWN0 flips that once so port 1 gets a turn.
    logic favor1;
    assign pick_last = favor1 ? P0 : P1;
`endif

    dmarb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_winner (pick_last),
        .win_vld     (win_vld),
        .win_id      (win_id)
    );

    // Grant decision for the current cycle, including the watchdog cut-off.
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        wd_fire = 1'b0;
        unique case (state)
            IDLE: begin
                grant0 = win_vld && (win_id == P0);
                grant1 = win_vld && (win_id == P1);
            end
            OWN0: begin
                if (lock_cnt == CNT_MAX) wd_fire = 1'b1;
                else                     grant0  = req0;
            end
            OWN1: begin
                if (lock_cnt == CNT_MAX) wd_fire = 1'b1;
                else                     grant1  = req1;
            end
            default: ;
        endcase
        if (reset) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign gnt0 = grant0;
    assign gnt1 = grant1;

    // Memory-side mux; idle cycles present zero address/data.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant0) begin
            mem_rd    = ~we0;
            mem_wr    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (grant1) begin
            mem_rd    = ~we1;
            mem_wr    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign rdata0 = mem_rdata;
    assign rdata1 = mem_rdata;
    // Masking with reset cancels a read response that is due in the same
    // cycle reset arrives.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;

    // Ownership FSM, lock counter and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= grant0 & ~we0;
            rvalid1_q <= grant1 & ~we1;
            unique case (state)
                IDLE: begin
                    if (grant0 && lock0) begin
                        state    <= OWN0;
                        lock_cnt <= CW'(1);
                    end else if (grant1 && lock1) begin
                        state    <= OWN1;
                        lock_cnt <= CW'(1);
                    end
                end
                OWN0: begin
                    if (!wd_fire && grant0 && lock0) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end else begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end
                end
                OWN1: begin
                    if (!wd_fire && grant1 && lock1) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end else begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DMARB_RR_EN
    // Remember the most recent winner for round-robin contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= P1;
        end else if (grant0) begin
            last_winner <= P0;
        end else if (grant1) begin
            last_winner <= P1;
        end
    end
`else
    // One-shot preference for port 1 after port 0's lock is cut off.
    always_ff @(posedge clk) begin
        if (reset) begin
            favor1 <= 1'b0;
        end else if (wd_fire && (state == OWN0)) begin
            favor1 <= 1'b1;
        end else if (grant0 || grant1) begin
            favor1 <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter (LOCK_MAX=4), with a
// simple 256-word memory model behind the arbiter.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .LOCK_MAX (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    // Memory model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem_rdata = '0;
        idle_inputs();

        // Reset held two cycles with both ports requesting.
        reset = 1; req0 = 1; req1 = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_gnt0", {31'b0, gnt0}, 32'd0);
            check("rst_gnt1", {31'b0, gnt1}, 32'd0);
            check("rst_memrw", {30'b0, mem_rd, mem_wr}, 32'd0);
            check("rst_rvalid", {30'b0, rvalid0, rvalid1}, 32'd0);
            next();
        end
        reset = 0;

        // Both ports read every cycle.
        req0 = 1; addr0 = 32'h20; req1 = 1; addr1 = 32'h21;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
`ifdef DMARB_RR_EN
            check("cont_gnt0", {31'b0, gnt0}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_gnt1", {31'b0, gnt1}, (c % 2 == 0) ? 32'd0 : 32'd1);
            if (c > 0) check("cont_rvalid0", {31'b0, rvalid0}, (c % 2 == 1) ? 32'd1 : 32'd0);
`else
            check("cont_gnt0", {31'b0, gnt0}, 32'd1);
            check("cont_gnt1", {31'b0, gnt1}, 32'd0);
            if (c > 0) check("cont_rvalid0", {31'b0, rvalid0}, 32'd1);
`endif
            next();
        end
        idle_inputs();

        // Port 0 write then read back.
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_gnt0", {31'b0, gnt0}, 32'd1);
        check("wr_memwr", {30'b0, mem_rd, mem_wr}, 32'd1);
        check("wr_addr", mem_addr, 32'h10);
        check("wr_wdata", mem_wdata, 32'hDEADBEEF);
        next();
        we0 = 0;
        @(negedge clk);
        check("rd_memrd", {30'b0, mem_rd, mem_wr}, 32'd2);
        check("wr_no_rvalid", {31'b0, rvalid0}, 32'd0);
        next();
        req0 = 0;
        @(negedge clk);
        check("rd_rvalid0", {31'b0, rvalid0}, 32'd1);
        check("rd_rdata0", rdata0, 32'hDEADBEEF);
        check("rd_rvalid1", {31'b0, rvalid1}, 32'd0);
        check("idle_addr", mem_addr, 32'h0);
        check("idle_memrw", {30'b0, mem_rd, mem_wr}, 32'd0);
        next();

        // Port 1 locked burst of three writes while port 0 waits.
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'h30; wdata1 = 32'h11;
        @(negedge clk);
        check("lk_gnt1_a", {30'b0, gnt0, gnt1}, 32'd1);
        next();
        req0 = 1; we0 = 0; addr0 = 32'h10;
        addr1 = 32'h31; wdata1 = 32'h22;
        @(negedge clk);
        check("lk_gnt1_b", {30'b0, gnt0, gnt1}, 32'd1);
        next();
        lock1 = 0; addr1 = 32'h32; wdata1 = 32'h33;
        @(negedge clk);
        check("lk_gnt1_c", {30'b0, gnt0, gnt1}, 32'd1);
        next();
        req1 = 0; we1 = 0;
        @(negedge clk);
        check("lk_after_gnt0", {30'b0, gnt0, gnt1}, 32'd2);
        next();
        req0 = 0;
        @(negedge clk);
        check("lk_rdata0", rdata0, 32'hDEADBEEF);
        check("lk_rvalid0", {31'b0, rvalid0}, 32'd1);
        next();

        // Watchdog: port 0 locks forever, port 1 pending.
        req0 = 1; lock0 = 1; addr0 = 32'h30;
        @(negedge clk);
        check("wd_gnt_1", {30'b0, gnt0, gnt1}, 32'd2);
        next();
        req1 = 1; we1 = 0; addr1 = 32'h31;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check("wd_gnt_own", {30'b0, gnt0, gnt1}, 32'd2);
            next();
        end
        @(negedge clk);
        check("wd_cut_gnt", {30'b0, gnt0, gnt1}, 32'd0);
        check("wd_cut_mem", {30'b0, mem_rd, mem_wr}, 32'd0);
        next();
        @(negedge clk);
        check("wd_gnt1", {30'b0, gnt0, gnt1}, 32'd1);
        next();
        idle_inputs();
        @(negedge clk);
        check("wd_rvalid1", {31'b0, rvalid1}, 32'd1);
        check("wd_rdata1", rdata1, 32'h22);
        next();

        // Reset right after a granted locked read.
        req0 = 1; lock0 = 1; addr0 = 32'h10;
        @(negedge clk);
        check("rr_gnt0", {31'b0, gnt0}, 32'd1);
        next();
        reset = 1; req0 = 0; lock0 = 0;
        @(negedge clk);
        check("rr_rvalid0", {31'b0, rvalid0}, 32'd0);
        next();
        reset = 0; req1 = 1; addr1 = 32'h10;
        @(negedge clk);
        check("rr_idle_gnt1", {30'b0, gnt0, gnt1}, 32'd1);
        check("rr_rvalid0_post", {31'b0, rvalid0}, 32'd0);
        next();
        idle_inputs();
        @(negedge clk);
        check("rr_rdata1", rdata1, 32'hDEADBEEF);
        next();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
